// File: rtl/fpu_issue_queue.sv
// Issue queue and result collector wrapped around a fixed-latency FPU core.
// A command FIFO feeds registered operands into the core. A valid/meta
// shift pipe tracks each issued op until its result appears, and that result
// is then captured into a result FIFO. Issue is gated by credits, so the
// result FIFO can never overflow.
module fpu_issue_queue #(
  parameter int CDEPTH  = 4,
  parameter int RDEPTH  = 4,
  parameter int FPU_LAT = 1,
  parameter int TAG_W   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [31:0]               in_a,
  input  logic [31:0]               in_b,
  input  logic [1:0]                in_opcode,
  input  logic [TAG_W-1:0]          in_tag,
  output logic [31:0]               fpu_a,
  output logic [31:0]               fpu_b,
  output logic [1:0]                fpu_opcode,
  input  logic [31:0]               fpu_outp,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [31:0]               out_result,
  output logic [TAG_W-1:0]          out_tag,
  output logic [1:0]                out_opcode,
  output logic [$clog2(RDEPTH):0]   inflight
);
  localparam int CW = $clog2(CDEPTH);
  localparam int RW = $clog2(RDEPTH);

  typedef struct packed {
    logic [31:0]      a;
    logic [31:0]      b;
    logic [1:0]       op;
    logic [TAG_W-1:0] tag;
  } cmd_t;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [1:0]       op;
  } meta_t;

  typedef struct packed {
    logic [31:0] res;
    meta_t       meta;
  } res_t;

  cmd_t  cmd_mem [CDEPTH];
  res_t  res_mem [RDEPTH];
  logic [CW:0] cmd_wr, cmd_rd;
  logic [RW:0] res_wr, res_rd, res_count;
  logic cmd_full, cmd_empty, res_full, res_empty;
  logic push, issue, capture, pop, credit_ok;

  logic  [FPU_LAT:0] vld_pipe;
  meta_t [FPU_LAT:0] meta_pipe;

  // Extra pointer bit distinguishes full from empty across wraps.
  assign cmd_full  = (cmd_wr ^ cmd_rd) == {1'b1, {CW{1'b0}}};
  assign cmd_empty = cmd_wr == cmd_rd;
  assign res_full  = (res_wr ^ res_rd) == {1'b1, {RW{1'b0}}};
  assign res_empty = res_wr == res_rd;
  assign res_count = res_wr - res_rd;

  // Credit uses registered counts, so a same-cycle pop frees nothing yet.
  assign credit_ok = ({1'b0, inflight} + {1'b0, res_count}) < (RW+2)'(RDEPTH);

  assign in_ready = !rst && !cmd_full;
  assign push     = in_valid && in_ready;
  assign issue    = !cmd_empty && credit_ok;
  assign capture  = vld_pipe[FPU_LAT];
  assign out_valid = !res_empty;
  assign pop      = out_valid && out_ready;

  assign out_result = res_mem[res_rd[RW-1:0]].res;
  assign out_tag    = res_mem[res_rd[RW-1:0]].meta.tag;
  assign out_opcode = res_mem[res_rd[RW-1:0]].meta.op;

  // Command FIFO: write on accept, advance read on issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_wr <= '0;
      cmd_rd <= '0;
    end else begin
      if (push) begin
        cmd_mem[cmd_wr[CW-1:0]] <= '{a: in_a, b: in_b, op: in_opcode, tag: in_tag};
        cmd_wr <= cmd_wr + 1'b1;
      end
      if (issue) cmd_rd <= cmd_rd + 1'b1;
    end
  end

  // Operand registers hold their last value when nothing issues.
  always_ff @(posedge clk) begin
    if (rst) begin
      fpu_a      <= '0;
      fpu_b      <= '0;
      fpu_opcode <= '0;
    end else if (issue) begin
      fpu_a      <= cmd_mem[cmd_rd[CW-1:0]].a;
      fpu_b      <= cmd_mem[cmd_rd[CW-1:0]].b;
      fpu_opcode <= cmd_mem[cmd_rd[CW-1:0]].op;
    end
  end

  // Valid/meta pipe that mirrors the core latency; its last slot marks capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe  <= '0;
      meta_pipe <= '0;
    end else begin
      vld_pipe[0]  <= issue;
      meta_pipe[0] <= '{tag: cmd_mem[cmd_rd[CW-1:0]].tag, op: cmd_mem[cmd_rd[CW-1:0]].op};
      for (int i = 1; i <= FPU_LAT; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        meta_pipe[i] <= meta_pipe[i-1];
      end
    end
  end

  // Result FIFO: write core output on capture, advance read on pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_wr <= '0;
      res_rd <= '0;
    end else begin
      if (capture) begin
        res_mem[res_wr[RW-1:0]] <= '{res: fpu_outp, meta: meta_pipe[FPU_LAT]};
        res_wr <= res_wr + 1'b1;
      end
      if (pop) res_rd <= res_rd + 1'b1;
    end
  end

  // Ops issued but not yet captured.
  always_ff @(posedge clk) begin
    if (rst) inflight <= '0;
    else begin
      case ({issue, capture})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
    end
  end

  // Credits guarantee room; a capture into a full FIFO is a design bug.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(capture && res_full));

endmodule

// File: tb/tb_fpu_issue_queue.sv
// Randomised and directed bench for fpu_issue_queue, with a queue-based
// reference model and a behavioural single-precision core.
module tb_fpu_issue_queue;
  localparam int CDEPTH = 4, RDEPTH = 4, FPU_LAT = 1, TAG_W = 4;

  logic clk = 0, rst = 1, in_valid = 0, out_ready = 0;
  logic [31:0] in_a = 0, in_b = 0, fpu_outp = 0;
  logic [1:0] in_opcode = 0;
  logic [TAG_W-1:0] in_tag = 0;
  logic in_ready, out_valid;
  logic [31:0] fpu_a, fpu_b, out_result;
  logic [1:0] fpu_opcode, out_opcode;
  logic [TAG_W-1:0] out_tag;
  logic [$clog2(RDEPTH):0] inflight;

  fpu_issue_queue #(.CDEPTH(CDEPTH), .RDEPTH(RDEPTH), .FPU_LAT(FPU_LAT), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_opcode(in_opcode), .in_tag(in_tag),
    .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_opcode(fpu_opcode), .fpu_outp(fpu_outp),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_tag(out_tag), .out_opcode(out_opcode), .inflight(inflight));

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h at %0t", n, act, exp, $time);
    end
  endtask

  // ---------------- behavioural float helpers ----------------
  function automatic real s2r(input logic [31:0] x);
    real r;
    int e;
    if (x[30:23] == 0) return 0.0;
    r = 1.0 + real'(x[22:0]) / 8388608.0;
    e = int'(x[30:23]) - 127;
    while (e > 0) begin r = r * 2.0; e--; end
    while (e < 0) begin r = r / 2.0; e++; end
    return x[31] ? -r : r;
  endfunction

  function automatic logic [31:0] r2s(input real r);
    logic [63:0] d;
    int e;
    d = $realtobits(r);
    if (d[62:0] == 0) return {d[63], 31'b0};
    e = int'(d[62:52]) - 1023 + 127;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] fp(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    case (op)
      2'd0: return r2s(s2r(a) + s2r(b));
      2'd1: return r2s(s2r(a) - s2r(b));
      2'd2: return (s2r(b) == 0.0) ? 32'h0 : r2s(s2r(a) / s2r(b));
      default: return r2s(s2r(a) * s2r(b));
    endcase
  endfunction

  function automatic logic [31:0] rf();
    return {1'($urandom), 8'($urandom_range(120, 134)), 23'($urandom)};
  endfunction

  // Core stand-in: one registered stage of arithmetic on the driven operands.
  initial forever begin
    @(posedge clk);
    fpu_outp <= fp(fpu_a, fpu_b, fpu_opcode);
  end

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] a, b, res;
    logic [1:0] op;
    logic [TAG_W-1:0] tag;
    int due;
  } ent_t;

  ent_t cmdq[$], infq[$], resq[$];
  logic [31:0] ma = 0, mb = 0;
  logic [1:0] mop = 0;
  int mcyc = 0;

  // Occupancy-level model: queues advance on the rules of accept/issue/capture/pop.
  initial forever begin
    ent_t e;
    bit p, c, s, acc;
    @(posedge clk);
    if (rst) begin
      cmdq.delete(); infq.delete(); resq.delete();
      ma = 0; mb = 0; mop = 0;
    end else begin
      p   = resq.size() > 0 && out_ready;
      c   = infq.size() > 0 && infq[0].due == mcyc;
      s   = cmdq.size() > 0 && (infq.size() + resq.size()) < RDEPTH;
      acc = in_valid && cmdq.size() < CDEPTH;
      if (p) void'(resq.pop_front());
      if (c) begin
        e = infq.pop_front();
        e.res = fp(e.a, e.b, e.op);
        resq.push_back(e);
      end
      if (s) begin
        e = cmdq.pop_front();
        e.due = mcyc + 1 + FPU_LAT;
        ma = e.a; mb = e.b; mop = e.op;
        infq.push_back(e);
      end
      if (acc) begin
        e.a = in_a; e.b = in_b; e.op = in_opcode; e.tag = in_tag; e.res = 0; e.due = 0;
        cmdq.push_back(e);
      end
    end
    mcyc++;
  end

  // Cycle-by-cycle compare of every output against the model.
  initial forever begin
    @(posedge clk);
    #2;
    chk("in_ready", in_ready, !rst && cmdq.size() < CDEPTH);
    chk("out_valid", out_valid, resq.size() > 0);
    chk("inflight", inflight, infq.size());
    chk("inflight_cap", inflight <= RDEPTH, 1);
    chk("fpu_a", fpu_a, ma);
    chk("fpu_b", fpu_b, mb);
    chk("fpu_opcode", fpu_opcode, mop);
    if (resq.size() > 0) begin
      chk("out_result", out_result, resq[0].res);
      chk("out_tag", out_tag, resq[0].tag);
      chk("out_opcode", out_opcode, resq[0].op);
    end
  end

  // DUT-side handshake log for directed literal checks.
  typedef struct { int cyc; logic [31:0] res; logic [TAG_W-1:0] tag; } pop_t;
  pop_t plog[$];
  int ncyc = 0, nacc = 0;
  initial forever begin
    pop_t q;
    @(posedge clk);
    if (!rst && out_valid && out_ready) begin
      q.cyc = ncyc; q.res = out_result; q.tag = out_tag;
      plog.push_back(q);
    end
    if (!rst && in_valid && in_ready) nacc++;
    ncyc++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                      input logic [TAG_W-1:0] tag);
    int t;
    in_a = a; in_b = b; in_opcode = op; in_tag = tag; in_valid = 1; t = 0;
    while (!in_ready && t < 300) begin @(negedge clk); t++; end
    if (!in_ready) begin
      chk("send_timeout", 0, 1);
      in_valid = 0;
      return;
    end
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic drain();
    int t, quiet;
    t = 0; quiet = 0;
    while (quiet < 4 && t < 300) begin
      @(negedge clk);
      t++;
      quiet = (!out_valid && inflight == 0) ? quiet + 1 : 0;
    end
    if (quiet < 4) chk("drain_timeout", 0, 1);
  endtask

  bit tog_done;
  int base;

  initial begin
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);

    // Single ADD: 1.0 + 1.0, tag 3; result visible after three edges.
    send(32'h3F800000, 32'h3F800000, 2'd0, 4'd3);
    repeat (2) @(posedge clk);
    #2 chk("t1_not_yet", out_valid, 0);
    @(posedge clk);
    #2;
    chk("t1_valid", out_valid, 1);
    chk("t1_result", out_result, 32'h40000000);
    chk("t1_tag", out_tag, 3);
    chk("t1_op", out_opcode, 0);
    chk("t1_inflight", inflight, 0);
    @(negedge clk);
    out_ready = 1;
    drain();

    // Stream of 8 ADDs 2.0 + 1.0, results on consecutive cycles in tag order.
    plog.delete();
    for (int i = 0; i < 8; i++) send(32'h40000000, 32'h3F800000, 2'd0, TAG_W'(i));
    drain();
    chk("t2_count", plog.size(), 8);
    for (int i = 0; i < plog.size(); i++) begin
      chk("t2_result", plog[i].res, 32'h40400000);
      chk("t2_tag", plog[i].tag, i);
      if (i > 0) chk("t2_back2back", plog[i].cyc - plog[i-1].cyc, 1);
    end

    // Stalled consumer: 4 buffered results + 4 queued commands, then release.
    out_ready = 0;
    plog.delete();
    base = nacc;
    fork
      for (int i = 0; i < 10; i++) send(rf(), rf(), 2'($urandom), TAG_W'(i));
      begin
        repeat (30) @(negedge clk);
        chk("t3_in_ready", in_ready, 0);
        chk("t3_accepts", nacc - base, 8);
        chk("t3_inflight", inflight, 0);
        out_ready = 1;
      end
    join
    drain();
    chk("t3_count", plog.size(), 10);
    for (int i = 0; i < plog.size(); i++) chk("t3_order", plog[i].tag, i);

    // Consumer toggling each cycle under continuous input.
    tog_done = 0;
    fork
      begin
        for (int i = 0; i < 16; i++) send(rf(), rf(), 2'($urandom), TAG_W'(i));
        tog_done = 1;
      end
      while (!tog_done) begin @(negedge clk); out_ready = ~out_ready; end
    join
    out_ready = 1;
    drain();

    // Reset with work queued and in flight; afterwards only tag 9 returns.
    out_ready = 0;
    for (int i = 0; i < 6; i++) send(rf(), rf(), 2'($urandom), TAG_W'(i));
    rst = 1;
    @(posedge clk);
    #2;
    chk("t5_out_valid", out_valid, 0);
    chk("t5_inflight", inflight, 0);
    chk("t5_fpu_op", fpu_opcode, 0);
    chk("t5_in_ready", in_ready, 0);
    @(negedge clk);
    rst = 0;
    out_ready = 1;
    plog.delete();
    @(negedge clk);
    send(32'h3F800000, 32'h40000000, 2'd0, 4'd9);
    drain();
    chk("t5_count", plog.size(), 1);
    if (plog.size() > 0) begin
      chk("t5_tag", plog[0].tag, 9);
      chk("t5_result", plog[0].res, 32'h40400000);
    end

    // Long random run: gaps, random back-pressure, many pointer wraps.
    tog_done = 0;
    fork
      begin
        for (int i = 0; i < 48; i++) begin
          repeat ($urandom_range(0, 2)) @(negedge clk);
          send(rf(), rf(), 2'($urandom), TAG_W'($urandom));
        end
        tog_done = 1;
      end
      while (!tog_done) begin @(negedge clk); out_ready = 1'($urandom_range(0, 2) != 0); end
    join
    out_ready = 1;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
